// File: rtl/rf_context_ctrl.sv
// rf_context_ctrl
//   Bulk save/restore of the 32x32 register file through its 1024-bit
//   snapshot port, streamed word by word to/from data memory. The CPU is
//   stalled for the whole operation.
//
// Ports
//   CLK, RESET_N           clock, async active-low reset
//   SAVE_REQ, RESTORE_REQ  level requests (save has priority), taken in IDLE
//   CTX_ID                 context slot, latched on acceptance
//   BUSY, CPU_STALL        high in every state except IDLE
//   DONE                   one-cycle completion pulse
//   RF_READ_MEM/RF_OUT_DATA   snapshot read strobe / snapshot in
//   RF_WRITE_MEM/RF_IN_DATA   snapshot write strobe / snapshot out (= buffer)
//   MEM_*                  word-wide memory port with busywait handshake
module rf_context_ctrl #(
    parameter int          RF_LAT   = 1,
    parameter logic [31:0] CTX_BASE = 32'h0000_1000,
    parameter int          CTX_BITS = 2
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                SAVE_REQ,
    input  logic                RESTORE_REQ,
    input  logic [CTX_BITS-1:0] CTX_ID,
    output logic                BUSY,
    output logic                DONE,
    output logic                CPU_STALL,
    output logic                RF_READ_MEM,
    output logic                RF_WRITE_MEM,
    input  logic [1023:0]       RF_OUT_DATA,
    output logic [1023:0]       RF_IN_DATA,
    output logic                MEM_READ,
    output logic                MEM_WRITE,
    output logic [31:0]         MEM_ADDRESS,
    output logic [31:0]         MEM_WRITEDATA,
    input  logic [31:0]         MEM_READDATA,
    input  logic                MEM_BUSYWAIT
);

    typedef enum logic [2:0] {IDLE, SNAP, MWR, MRD, LOAD, FIN} state_e;

    // Last cycle index of an RF strobe: strobe lasts RF_LAT+1 cycles.
    localparam logic [3:0] LAT_LAST = 4'(RF_LAT);

    state_e              state_q, state_d;
    logic [CTX_BITS-1:0] ctx_q, ctx_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [3:0]          lat_q, lat_d;
    logic [1023:0]       buf_q, buf_d;
    logic [31:0]         word_addr;

    // 128 bytes per context, 4 bytes per word; 32-bit wrap-around.
    assign word_addr  = CTX_BASE + (32'(ctx_q) << 7) + (32'(cnt_q) << 2);
    assign RF_IN_DATA = buf_q;
    assign CPU_STALL  = BUSY;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            ctx_q   <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ctx_d         = ctx_q;
        cnt_d         = cnt_q;
        lat_d         = lat_q;
        buf_d         = buf_q;
        BUSY          = (state_q != IDLE);
        DONE          = 1'b0;
        RF_READ_MEM   = 1'b0;
        RF_WRITE_MEM  = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                lat_d = '0;
                if (SAVE_REQ) begin
                    ctx_d   = CTX_ID;
                    state_d = SNAP;
                end else if (RESTORE_REQ) begin
                    ctx_d   = CTX_ID;
                    state_d = MRD;
                end
            end
            SNAP: begin
                RF_READ_MEM = 1'b1;
                if (lat_q == LAT_LAST) begin
                    // Snapshot is valid only in the final strobe cycle.
                    buf_d   = RF_OUT_DATA;
                    cnt_d   = '0;
                    lat_d   = '0;
                    state_d = MWR;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            MWR: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = word_addr;
                MEM_WRITEDATA = buf_q[{cnt_q, 5'b0} +: 32];
                if (!MEM_BUSYWAIT) begin
                    if (cnt_q == 5'd31) state_d = FIN;
                    else                cnt_d   = cnt_q + 5'd1;
                end
            end
            MRD: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = word_addr;
                if (!MEM_BUSYWAIT) begin
                    buf_d[{cnt_q, 5'b0} +: 32] = MEM_READDATA;
                    if (cnt_q == 5'd31) begin
                        lat_d   = '0;
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            LOAD: begin
                RF_WRITE_MEM = 1'b1;
                if (lat_q == LAT_LAST) state_d = FIN;
                else                   lat_d   = lat_q + 4'd1;
            end
            FIN: begin
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/rf_context_ctrl.md
Name: rf_context_ctrl

Overview:
- Sequences bulk save/restore of the 32x32 register file through its 1024-bit snapshot port (READ_MEM/OUT_DATA, WRITE_MEM/IN_DATA), used for context switches and debug dumps.
- Streams the snapshot to or from word-wide data memory over a busywait handshake.
- Stalls the CPU for the whole operation.
- Sits between the register file, the data-memory arbiter and the pipeline stall logic.

Parameters:
- RF_LAT, 1, clock cycles the register file needs after a READ_MEM/WRITE_MEM posedge before the snapshot is valid or committed (1..15).
- CTX_BASE, 32'h0000_1000, byte base address of the context save area.
- CTX_BITS, 2, width of the context id; one context occupies 128 bytes.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- SAVE_REQ  in  1  level request: save register file to context CTX_ID.
- RESTORE_REQ  in  1  level request: restore register file from context CTX_ID.
- CTX_ID  in  CTX_BITS  context slot, sampled when a request is accepted.
- BUSY  out  1  high while any operation is in progress.
- DONE  out  1  one-cycle pulse when an operation completes.
- CPU_STALL  out  1  equals BUSY; freezes the pipeline.
- RF_READ_MEM  out  1  snapshot read strobe to the register file.
- RF_WRITE_MEM  out  1  snapshot write strobe to the register file.
- RF_OUT_DATA  in  1024  snapshot from the register file; word i = bits [32i+31:32i].
- RF_IN_DATA  out  1024  snapshot to the register file, driven from the internal buffer.
- MEM_READ  out  1  memory read request.
- MEM_WRITE  out  1  memory write request.
- MEM_ADDRESS  out  32  byte address.
- MEM_WRITEDATA  out  32  write data.
- MEM_READDATA  in  32  read data, valid in the cycle MEM_BUSYWAIT is low.
- MEM_BUSYWAIT  in  1  memory not ready; the request must be held.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - State IDLE.
  - All outputs 0; RF_IN_DATA = 0.
  - Buffer, word counter and latency counter cleared.
  - Applies immediately, including mid-operation. No DONE is produced for an aborted operation. Any partially written memory context is left as-is.
- States: IDLE, SNAP, MWR, MRD, LOAD, FIN.
- IDLE:
  - SAVE_REQ=1: latch CTX_ID, go to SNAP.
  - Else RESTORE_REQ=1: latch CTX_ID, go to MRD.
  - If both are high, save wins.
  - Requests arriving while not in IDLE are ignored. A request still high when the block returns to IDLE starts a new operation.
- SNAP:
  - RF_READ_MEM=1 for exactly RF_LAT+1 cycles.
  - In the last cycle, capture RF_OUT_DATA into the 1024-bit buffer.
  - Then RF_READ_MEM=0, word counter=0, go to MWR.
- MWR:
  - MEM_WRITE=1.
  - MEM_ADDRESS = CTX_BASE + CTX_ID*128 + 4*cnt.
  - MEM_WRITEDATA = buffer word cnt.
  - A word completes on a rising edge with MEM_WRITE=1 and MEM_BUSYWAIT=0.
  - Address and data are held stable while MEM_BUSYWAIT=1; no timeout.
  - On completion: cnt increments; after word 31, MEM_WRITE drops and the state goes to FIN.
  - No idle cycle between words.
- MRD:
  - MEM_READ=1, same addressing.
  - On a rising edge with MEM_BUSYWAIT=0, MEM_READDATA is stored into buffer word cnt.
  - After word 31, MEM_READ drops and the state goes to LOAD.
- LOAD:
  - RF_IN_DATA = buffer (RF_IN_DATA is also driven from the buffer in every other state).
  - RF_WRITE_MEM=1 for RF_LAT+1 cycles, then go to FIN.
- FIN: DONE=1 for one cycle, BUSY=0 from the next cycle, return to IDLE.
- BUSY=1 in every state except IDLE. BUSY rises the cycle after the request is accepted.
- MEM_READ, MEM_WRITE, RF_READ_MEM and RF_WRITE_MEM are mutually exclusive and never high in IDLE or FIN.
- Arithmetic:
  - Address uses 32-bit unsigned wrap-around.
  - The word counter is 5 bits; the last-word test is cnt==31 combined with completion, never counter overflow.
- Latency:
  - Save with no memory wait = 1 + (RF_LAT+1) + 32 + 1 cycles from acceptance to DONE.
  - Restore with no memory wait = 1 + 32 + (RF_LAT+1) + 1 cycles.
- Register-file writes through the normal WRITE port are not arbitrated here; CPU_STALL guarantees there are none during an operation.

Test Plan:
- Save, no wait: RF words k = 32'hA000_0000+k, CTX_ID=1, RF_LAT=1 → 32 consecutive writes, addresses 32'h1080..32'h10FC, data A000_0000..A000_001F in order; DONE exactly 36 cycles after acceptance; RF_READ_MEM high exactly 2 cycles.
- Restore with waits: memory returns 32'h5500_0000+k for word k, BUSYWAIT=1 for 2 cycles per word, CTX_ID=3 → reads from 32'h1180..32'h11FC; after DONE, every RF word k = 5500_0000+k; RF_WRITE_MEM high exactly 2 cycles.
- Simultaneous SAVE_REQ=RESTORE_REQ=1 in IDLE → save runs, MEM_READ never asserted. RESTORE_REQ held high afterwards → restore starts the cycle after DONE.
- Request during an operation: pulse RESTORE_REQ mid-MWR with CTX_ID changed to 2 → ignored; addresses continue at the original context; exactly one DONE.
- Reset mid-operation: RESET_N low after word 10 of MWR → same-instant MEM_WRITE=0, BUSY=0, CPU_STALL=0; no DONE. After release, a new save restarts at word 0.
- RF_LAT=3, save → RF_READ_MEM high 4 cycles, capture happens in the 4th; data written to memory matches the RF contents bit-exactly, including words 6 and 20.
